rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and busy-register scoreboard for the pipelined CPU's single-write-port register file. Shares the RF write port between the in-order pipeline writeback stage and one long-latency unit (mul/div). The long-latency unit hands results over through a one-entry holding register. A starvation counter forces a one-cycle pipeline freeze so held results always drain. A per-register busy vector tells decode which source registers still await a long-latency result.

## Interface
- STARVE_LIMIT, 4: consecutive lost arbitration cycles before the held result forces a pipeline freeze (1..15).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  pipeline writeback request
- wb_rd  in  5  pipeline destination register
- wb_wd  in  32  pipeline write data
- md_issue  in  1  long-latency op issued this cycle
- md_issue_rd  in  5  its destination register
- md_valid  in  1  long-latency result valid
- md_rd  in  5  result destination register
- md_wd  in  32  result data
- md_ready  out  1  arbiter can accept a result
- rs1, rs2  in  5  decode-stage source registers
- rs1_busy, rs2_busy  out  1  source awaits a long-latency result
- stall_pipe  out  1  pipeline must freeze this cycle
- rf_we  out  1  RF write enable
- rf_wa  out  5  RF write address
- rf_wd  out  32  RF write data

## Operation
- State: hold_v, hold_rd[4:0], hold_wd[31:0], wait_cnt[3:0], busy[31:1].
- Effective pipeline request: wb_req = wb_we && wb_rd != 0. Writes to x0 are dropped (rf_we=0).
- md_ready = !hold_v && !rst. A handshake (md_valid && md_ready) loads hold_v=1, hold_rd=md_rd, hold_wd=md_wd. A result with md_rd==0 is accepted and discarded (hold_v stays 0).
- stall_pipe = hold_v && wait_cnt >= STARVE_LIMIT. This is a function of registered state only.
- Grant: md_grant = hold_v && (stall_pipe || !wb_req). The pipeline is granted when wb_req && !md_grant.
- Outputs:
  - md_grant: rf_we=1, rf_wa=hold_rd, rf_wd=hold_wd.
  - pipeline grant: rf_we=1, rf_wa=wb_rd, rf_wd=wb_wd.
  - otherwise: rf_we=0, rf_wa=0, rf_wd=0.
- If stall_pipe is asserted while wb_req is high, the pipeline write is not performed. The frozen pipeline re-presents it next cycle.
- md_grant clears hold_v and wait_cnt. A new result cannot be accepted in the same cycle, because md_ready was 0.
- hold_v && !md_grant: wait_cnt increments, saturating at 15. !hold_v: wait_cnt=0.
- Scoreboard:
  - md_issue && md_issue_rd!=0 sets busy[md_issue_rd].
  - md_grant clears busy[hold_rd].
  - Set and clear of the same bit in one cycle: set wins.
- rsN_busy = rsN!=0 && busy[rsN] && !(md_grant && hold_rd==rsN). The clear is bypassed because the RF captures data on the negative edge, so decode sees it at the next rising edge.
- Upstream must not issue to an already-busy rd. If it does, the bit stays set and is cleared by the first return.

## Timing
- Reset (rst=1 at a rising edge): hold_v=0, wait_cnt=0, busy=0.
- While rst is high: rf_we=0, rf_wa=0, rf_wd=0, md_ready=0, stall_pipe=0, rs1_busy=rs2_busy=0. All inputs are ignored.
- Reset mid-operation discards a held result without writing it.
- Pipeline write: zero latency. Inputs pass combinationally to rf_* in the same cycle.
- Long-latency result, uncontended: accepted at edge N, written to the RF in cycle N+1. md_ready returns high in cycle N+2.
- Worst-case held wait: STARVE_LIMIT cycles of continuous wb_req, then a one-cycle stall_pipe with the write. stall_pipe never lasts more than one consecutive cycle.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: busy vector and rs1_busy/rs2_busy as specified.
- Undefined: no busy storage, rs1_busy=rs2_busy=0, md_issue/md_issue_rd ignored. The pipeline must then interlock on the long-latency unit by other means. Arbitration is unchanged.

## Test plan
- Reset: assert rst with md_valid=1 and wb_we=1 -> rf_we=0, md_ready=0. After release, md_ready=1 and rs1_busy=0 for every rs1.
- Pipeline only: wb_we=1, wb_rd=5, wb_wd=0x1234 -> same cycle rf_we=1, rf_wa=5, rf_wd=0x1234. With wb_rd=0 -> rf_we=0.
- Uncontended return: md_issue rd=7, then md_valid rd=7 wd=0xDEADBEEF with wb_we=0.
  - rs1=7 shows busy until the write cycle.
  - Next cycle rf_wa=7, rf_wd=0xDEADBEEF; rs1_busy=0 in that same cycle.
  - md_ready=1 one cycle later.
- Starvation (STARVE_LIMIT=4): result held while wb_we=1 on x3 every cycle.
  - 4 cycles of pipeline writes to x3.
  - Fifth cycle: stall_pipe=1 and the held write goes to the RF.
  - Sixth cycle: the pipeline write to x3 resumes and stall_pipe=0.
- Simultaneous events: md_grant clearing busy[9] in the same cycle as md_issue rd=9 -> busy[9] stays 1. md_valid presented while hold_v=1 -> md_ready=0, no capture, and the held data is unchanged.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// RF write-port arbiter: pipeline writeback passes through combinationally; one held mul/div result drains when the port is free or via a forced one-cycle stall_pipe.
// Define RF_ARB_SCOREBOARD_EN to build the per-register busy scoreboard behind o_rs1_busy/o_rs2_busy.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_wd,
  input  logic        i_md_issue,
  input  logic [4:0]  i_md_issue_rd,
  input  logic        i_md_valid,
  input  logic [4:0]  i_md_rd,
  input  logic [31:0] i_md_wd,
  output logic        o_md_ready,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_stall_pipe,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_wa,
  output logic [31:0] o_rf_wd
);

  logic        r_hold_v;
  logic [4:0]  r_hold_rd;
  logic [31:0] r_hold_wd;
  logic [3:0]  r_wait_cnt;

  logic w_wb_req;
  logic w_stall;
  logic w_md_grant;
  logic w_wb_grant;
  logic w_md_accept;

  assign w_wb_req    = i_wb_we && (i_wb_rd != 5'd0);
  assign o_md_ready  = !r_hold_v && !i_rst;
  assign w_md_accept = i_md_valid && o_md_ready;
  // Stall depends only on registered state so it never loops back through wb_we.
  assign w_stall     = !i_rst && r_hold_v && (r_wait_cnt >= 4'(STARVE_LIMIT));
  assign w_md_grant  = !i_rst && r_hold_v && (w_stall || !w_wb_req);
  assign w_wb_grant  = !i_rst && w_wb_req && !w_md_grant;
  assign o_stall_pipe = w_stall;

  always_comb begin
    o_rf_we = 1'b0;
    o_rf_wa = 5'd0;
    o_rf_wd = 32'd0;
    if (w_md_grant) begin
      o_rf_we = 1'b1;
      o_rf_wa = r_hold_rd;
      o_rf_wd = r_hold_wd;
    end else if (w_wb_grant) begin
      o_rf_we = 1'b1;
      o_rf_wa = i_wb_rd;
      o_rf_wd = i_wb_wd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_v   <= 1'b0;
      r_hold_rd  <= 5'd0;
      r_hold_wd  <= 32'd0;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_md_grant) begin
        r_hold_v   <= 1'b0;
        r_wait_cnt <= 4'd0;
      end else if (r_hold_v) begin
        if (r_wait_cnt != 4'hF) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'd0;
      end
      // Results aimed at x0 complete the handshake but are dropped here.
      if (w_md_accept && (i_md_rd != 5'd0)) begin
        r_hold_v  <= 1'b1;
        r_hold_rd <= i_md_rd;
        r_hold_wd <= i_md_wd;
      end
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:1] r_busy;
  logic [31:1] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < 32; i++) begin
      if (w_md_grant && (r_hold_rd == 5'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
      if (i_md_issue && (i_md_issue_rd == 5'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Bypass the clear: the RF captures on the falling edge, so decode reads fresh data next cycle.
  assign o_rs1_busy = !i_rst && (i_rs1 != 5'd0) && r_busy[i_rs1] &&
                      !(w_md_grant && (r_hold_rd == i_rs1));
  assign o_rs2_busy = !i_rst && (i_rs2 != 5'd0) && r_busy[i_rs2] &&
                      !(w_md_grant && (r_hold_rd == i_rs2));
`else
  logic w_sb_unused;
  assign w_sb_unused = ^{i_md_issue, i_md_issue_rd, i_rs1, i_rs2};
  assign o_rs1_busy  = 1'b0;
  assign o_rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: per-cycle reference model compare plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
  localparam int unsigned LIMIT = 4;
`ifdef RF_ARB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_wd;
  logic        md_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_wd(wb_wd),
    .i_md_issue(md_issue), .i_md_issue_rd(md_issue_rd),
    .i_md_valid(md_valid), .i_md_rd(md_rd), .i_md_wd(md_wd),
    .o_md_ready(md_ready),
    .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_stall_pipe(stall_pipe),
    .o_rf_we(rf_we), .o_rf_wa(rf_wa), .o_rf_wd(rf_wd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a single pending result, how long it has been waiting, and the set of busy registers.
  logic        m_pend = 1'b0, n_pend = 1'b0;
  logic [4:0]  m_prd  = '0,   n_prd  = '0;
  logic [31:0] m_pwd  = '0,   n_pwd  = '0;
  int          m_wait = 0,    n_wait = 0;
  bit   [31:0] m_busy = '0,   n_busy = '0;

  always @(negedge clk) begin
    logic        req, stall, drain, e_we, e_r1, e_r2;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    if (rst) begin
      chk("rst_rf_we", rf_we, 0);   chk("rst_rf_wa", rf_wa, 0);
      chk("rst_rf_wd", rf_wd, 0);   chk("rst_ready", md_ready, 0);
      chk("rst_stall", stall_pipe, 0);
      chk("rst_rs1b", rs1_busy, 0); chk("rst_rs2b", rs2_busy, 0);
      n_pend = 0; n_wait = 0; n_busy = '0; n_prd = '0; n_pwd = '0;
    end else begin
      req   = wb_we && wb_rd != 0;
      stall = m_pend && m_wait >= LIMIT;
      drain = m_pend && (stall || !req);
      e_we = drain || req;
      e_wa = drain ? m_prd : (req ? wb_rd : 5'd0);
      e_wd = drain ? m_pwd : (req ? wb_wd : 32'd0);
      e_r1 = SB && rs1 != 0 && m_busy[rs1] && !(drain && m_prd == rs1);
      e_r2 = SB && rs2 != 0 && m_busy[rs2] && !(drain && m_prd == rs2);
      chk("rf_we", rf_we, e_we);  chk("rf_wa", rf_wa, e_wa);
      chk("rf_wd", rf_wd, e_wd);  chk("md_ready", md_ready, !m_pend);
      chk("stall", stall_pipe, stall);
      chk("rs1_busy", rs1_busy, e_r1); chk("rs2_busy", rs2_busy, e_r2);
      n_busy = m_busy;
      if (drain) n_busy[m_prd] = 1'b0;
      if (md_issue && md_issue_rd != 0) n_busy[md_issue_rd] = 1'b1;
      n_prd = m_prd; n_pwd = m_pwd;
      if (drain) begin
        n_pend = 0; n_wait = 0;
      end else if (m_pend) begin
        n_pend = 1; n_wait = (m_wait < 15) ? m_wait + 1 : 15;
      end else begin
        n_pend = md_valid && md_rd != 0; n_wait = 0;
        if (n_pend) begin n_prd = md_rd; n_pwd = md_wd; end
      end
    end
  end

  always @(posedge clk) begin
    m_pend <= n_pend; m_prd <= n_prd; m_pwd <= n_pwd;
    m_wait <= n_wait; m_busy <= n_busy;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; wb_we = 1; wb_rd = 5; wb_wd = 32'h77; md_issue = 0; md_issue_rd = 0;
    md_valid = 1; md_rd = 3; md_wd = 32'h33; rs1 = 0; rs2 = 0;
    #2;
    chk("lit_rst_we", rf_we, 0); chk("lit_rst_ready", md_ready, 0);
    cyc();
    cyc();
    rst = 0; wb_we = 0; wb_rd = 0; wb_wd = 0; md_valid = 0; md_rd = 0; md_wd = 0;
    #1 chk("lit_ready_after_rst", md_ready, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(); rs1 = 5'(i); rs2 = 5'(31 - i);
      #1 chk("lit_rs1_idle", rs1_busy, 0);
    end

    cyc(); wb_we = 1; wb_rd = 5; wb_wd = 32'h1234;
    #1 chk("lit_wb_we", rf_we, 1); chk("lit_wb_wa", rf_wa, 5); chk("lit_wb_wd", rf_wd, 32'h1234);
    cyc(); wb_rd = 0;
    #1 chk("lit_x0_we", rf_we, 0); chk("lit_x0_wa", rf_wa, 0);
    cyc(); wb_we = 0; md_issue = 1; md_issue_rd = 7; rs1 = 7; rs2 = 0;
    #1 chk("lit_pre_issue_busy", rs1_busy, 0);
    cyc(); md_issue = 0; md_valid = 1; md_rd = 7; md_wd = 32'hDEADBEEF;
    #1 chk("lit_busy7", rs1_busy, SB); chk("lit_ready_acc", md_ready, 1); chk("lit_acc_we", rf_we, 0);
    cyc(); md_valid = 0;
    #1 chk("lit_md_we", rf_we, 1); chk("lit_md_wa", rf_wa, 7);
    chk("lit_md_wd", rf_wd, 32'hDEADBEEF); chk("lit_bypass7", rs1_busy, 0); chk("lit_ready_low", md_ready, 0);
    cyc();
    #1 chk("lit_ready_back", md_ready, 1); chk("lit_idle_we", rf_we, 0); chk("lit_clear7", rs1_busy, 0);

    cyc(); md_valid = 1; md_rd = 12; md_wd = 32'hA5A50012; wb_we = 1; wb_rd = 3; wb_wd = 32'h333;
    #1 chk("lit_st0_wa", rf_wa, 3);
    for (int k = 1; k <= 4; k++) begin
      cyc(); md_valid = (k == 2); md_rd = 20; md_wd = 32'hFFFFFFFF;
      #1 chk("lit_st_wa", rf_wa, 3); chk("lit_st_nostall", stall_pipe, 0); chk("lit_st_ready", md_ready, 0);
    end
    cyc(); md_valid = 0;
    #1 chk("lit_st5_stall", stall_pipe, 1); chk("lit_st5_we", rf_we, 1);
    chk("lit_st5_wa", rf_wa, 12); chk("lit_st5_wd", rf_wd, 32'hA5A50012);
    cyc();
    #1 chk("lit_st6_stall", stall_pipe, 0); chk("lit_st6_wa", rf_wa, 3); chk("lit_st6_ready", md_ready, 1);

    cyc(); wb_we = 0; md_issue = 1; md_issue_rd = 9; rs1 = 9; rs2 = 9;
    cyc(); md_issue = 0; md_valid = 1; md_rd = 9; md_wd = 32'h99;
    #1 chk("lit_busy9", rs1_busy, SB);
    cyc(); md_valid = 0; md_issue = 1; md_issue_rd = 9;
    #1 chk("lit_sim_wa", rf_wa, 9); chk("lit_sim_bypass", rs1_busy, 0);
    cyc(); md_issue = 0;
    #1 chk("lit_set_wins", rs1_busy, SB);
    cyc(); md_valid = 1; md_rd = 9; md_wd = 32'h98;
    cyc(); md_valid = 0;
    #1 chk("lit_ret9_wd", rf_wd, 32'h98); chk("lit_ret9_bypass", rs1_busy, 0);
    cyc();
    #1 chk("lit_ret9_clear", rs1_busy, 0);

    cyc(); md_valid = 1; md_rd = 0; md_wd = 32'h55;
    cyc(); md_valid = 0;
    #1 chk("lit_x0_ready", md_ready, 1); chk("lit_x0_nowrite", rf_we, 0);

    cyc(); md_valid = 1; md_rd = 15; md_wd = 32'hF; wb_we = 1; wb_rd = 4; wb_wd = 32'h44;
    cyc(); md_valid = 0; rst = 1;
    #1 chk("lit_mid_rst_we", rf_we, 0); chk("lit_mid_rst_ready", md_ready, 0);
    cyc(); rst = 0; wb_we = 0;
    #1 chk("lit_post_rst_we", rf_we, 0); chk("lit_post_rst_ready", md_ready, 1);
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
